// File: rtl/aes_encrypt_controller.sv
// -----------------------------------------------------------------------------
// aes_encrypt_controller
//   Iterative AES-128 forward cipher. One round per clock, round keys expanded
//   on the fly from the previous round key, ciphertext held for the host side.
//
// Ports
//   Clk        : clock, all state updates on the rising edge
//   Reset      : asynchronous, active-high reset
//   msg_de     : 128-bit plaintext (byte 0 = bits [127:120], column-major)
//   key        : 128-bit cipher key, same byte order
//   io_ready   : host level request; high starts, low acknowledges the result
//   msg_en     : 128-bit ciphertext register
//   aes_ready  : result valid, high only in DONE
//   cur_state  : debug view of the FSM (IDLE=0, ROUND=1, FINAL=2, DONE=3)
// -----------------------------------------------------------------------------
module aes_encrypt_controller (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [127:0] msg_de,
  input  logic [127:0] key,
  input  logic         io_ready,
  output logic [127:0] msg_en,
  output logic         aes_ready,
  output logic [7:0]   cur_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset (255-x)*8, which is simply {~x, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t       state, state_next;
  logic [127:0] st, rk;
  logic [3:0]   rnd;

  // ---------------------------------------------------------------------------
  // Key step: next round key from the current one, using rnd for Rcon.
  // ---------------------------------------------------------------------------
  logic [31:0]  w0, w1, w2, w3, w4, w5, w6, w7, sub_rot;
  logic [127:0] rk_next;

  assign w0      = rk[127:96];
  assign w1      = rk[95:64];
  assign w2      = rk[63:32];
  assign w3      = rk[31:0];
  // RotWord then SubWord: bytes of w3 taken as [1,2,3,0].
  assign sub_rot = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
  assign w4      = w0 ^ sub_rot ^ {rcon(rnd), 24'h0};
  assign w5      = w1 ^ w4;
  assign w6      = w2 ^ w5;
  assign w7      = w3 ^ w6;
  assign rk_next = {w4, w5, w6, w7};

  // ---------------------------------------------------------------------------
  // Round datapath: SubBytes -> ShiftRows -> MixColumns.
  // Byte i of the state (row i%4, column i/4) lives at bits [127-8i -: 8].
  // ---------------------------------------------------------------------------
  logic [127:0] sb, sr, mc;
  logic [7:0]   a0, a1, a2, a3;

  // NOTE: every variable assigned in an always_comb gets a default first, so no
  // path through the block can leave a value held and infer a latch.
  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int i = 0; i < 16; i++) begin
      sb[8*i +: 8] = sbox(st[8*i +: 8]);
    end
    // Row r of column c takes the byte from column (c+r) mod 4: left rotate by r.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[127-32*c -: 8];
      a1 = sr[119-32*c -: 8];
      a2 = sr[111-32*c -: 8];
      a3 = sr[103-32*c -: 8];
      mc[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register in
  // the design samples pre-edge values, independent of block ordering.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (io_ready) state_next = ROUND;
      ROUND:   if (rnd == 4'd9) state_next = FINAL;
      FINAL:   state_next = DONE;
      DONE:    if (!io_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. Inputs are captured only on the starting edge in IDLE;
  // io_ready is ignored while a block is in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      st     <= '0;
      rk     <= '0;
      rnd    <= '0;
      msg_en <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io_ready) begin
            st  <= msg_de ^ key;
            rk  <= key;
            rnd <= 4'd1;
          end
        end
        ROUND: begin
          st  <= mc ^ rk_next;
          rk  <= rk_next;
          rnd <= rnd + 4'd1;
        end
        FINAL: begin
          // Last round skips MixColumns.
          st     <= sr ^ rk_next;
          rk     <= rk_next;
          msg_en <= sr ^ rk_next;
        end
        default: ;
      endcase
    end
  end

  assign aes_ready = (state == DONE);
  assign cur_state = {6'd0, state};

endmodule

// File: tb/tb_aes_encrypt_controller.sv
// -----------------------------------------------------------------------------
// tb_aes_encrypt_controller
//   Directed bench. A textbook AES-128 reference (S-box derived from GF(2^8)
//   inverses, full key schedule) predicts ciphertexts; a transaction-level
//   timing model predicts cur_state / aes_ready / msg_en every cycle.
// -----------------------------------------------------------------------------
module tb_aes_encrypt_controller;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [127:0] msg_de, key;
  logic         io_ready;
  logic [127:0] msg_en;
  logic         aes_ready;
  logic [7:0]   cur_state;

  aes_encrypt_controller dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .msg_de    (msg_de),
    .key       (key),
    .io_ready  (io_ready),
    .msg_en    (msg_en),
    .aes_ready (aes_ready),
    .cur_state (cur_state)
  );

  always #5 Clk = ~Clk;

  localparam logic [127:0] ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] C_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference AES-128
  // ---------------------------------------------------------------------------
  logic [7:0] sbox_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]], sbox_m[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row+4*c] = s[row+4*((c+row)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  // ---------------------------------------------------------------------------
  // Timing model: idle / busy (edges since start) / done.
  // ---------------------------------------------------------------------------
  int           m_phase = 0;   // 0 idle, 1 busy, 2 done
  int           m_cnt   = 0;
  logic [127:0] m_pending = '0;
  logic [127:0] m_msg_en  = '0;
  logic         cmp_en    = 1'b0;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_phase  = 0;
      m_cnt    = 0;
      m_msg_en = '0;
    end else begin
      case (m_phase)
        0: if (io_ready) begin
             m_pending = aes_ref(msg_de, key);
             m_cnt     = 1;
             m_phase   = 1;
           end
        1: if (m_cnt == 10) begin
             m_msg_en = m_pending;
             m_phase  = 2;
           end else begin
             m_cnt++;
           end
        default: if (!io_ready) m_phase = 0;
      endcase
    end
  end

  function automatic logic [7:0] exp_state();
    if (m_phase == 0) return 8'd0;
    if (m_phase == 1) return (m_cnt == 10) ? 8'd2 : 8'd1;
    return 8'd3;
  endfunction

  always @(negedge Clk) begin
    if (cmp_en && !Reset) begin
      check("cur_state", 128'(cur_state), 128'(exp_state()));
      check("aes_ready", 128'(aes_ready), 128'(m_phase == 2));
      check("msg_en",    msg_en, m_msg_en);
    end
  end

  // Waits until aes_ready, counting negedges into edges; bounded.
  task automatic wait_ready(inout int edges);
    while (!aes_ready && edges < 40) begin
      @(negedge Clk);
      edges++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int           edges;
  int           span;
  logic [127:0] rnd_pt, rnd_key;

  initial begin
    build_sbox();
    Reset    = 1'b1;
    io_ready = 1'b0;
    msg_de   = '0;
    key      = '0;
    #1;
    check("reset_state", 128'(cur_state), 128'd0);
    check("reset_ready", 128'(aes_ready), 128'd0);
    check("reset_msg",   msg_en, 128'd0);
    repeat (2) @(negedge Clk);
    Reset  = 1'b0;
    cmp_en = 1'b1;

    // Pin the reference model to published vectors.
    check("model_zero", aes_ref('0, '0), ZERO_CT);
    check("model_b",    aes_ref(B_PT, B_KEY), B_CT);
    check("model_c1",   aes_ref(C_PT, C_KEY), C_CT);

    // Zero vector, single-cycle io_ready pulse; latency counts E0..E10.
    @(negedge Clk);
    msg_de = '0; key = '0; io_ready = 1'b1;
    @(negedge Clk);
    io_ready = 1'b0;
    edges = 1;
    wait_ready(edges);
    check("zero_latency", 128'(edges), 128'd11);
    check("zero_ct", msg_en, ZERO_CT);
    @(negedge Clk);

    // Appendix B with input disturbance while busy.
    msg_de = B_PT; key = B_KEY; io_ready = 1'b1;
    @(negedge Clk);
    io_ready = 1'b0;
    msg_de = {$urandom, $urandom, $urandom, $urandom};
    key    = {$urandom, $urandom, $urandom, $urandom};
    @(negedge Clk);
    check("b_rk_round1", dut.rk, B_RK1);
    io_ready = 1'b1;
    @(negedge Clk);
    io_ready = 1'b0;
    key = ~key;
    @(negedge Clk);
    io_ready = 1'b1;
    edges = 4;
    wait_ready(edges);
    check("b_latency", 128'(edges), 128'd11);
    check("b_ct", msg_en, B_CT);

    // io_ready held: stays in DONE, no restart.
    repeat (30) @(negedge Clk);
    check("hold_state", 128'(cur_state), 128'd3);
    check("hold_ready", 128'(aes_ready), 128'd1);
    io_ready = 1'b0;
    @(negedge Clk);
    check("ack_state", 128'(cur_state), 128'd0);
    check("ack_ready", 128'(aes_ready), 128'd0);
    check("ack_msg",   msg_en, B_CT);

    // C.1 then a back-to-back random vector at minimum turnaround.
    msg_de = C_PT; key = C_KEY; io_ready = 1'b1;
    @(negedge Clk);
    edges = 1;
    wait_ready(edges);
    check("c1_latency", 128'(edges), 128'd11);
    check("c1_ct", msg_en, C_CT);
    span = edges;
    io_ready = 1'b0;
    @(negedge Clk);
    span++;
    rnd_pt  = {$urandom, $urandom, $urandom, $urandom};
    rnd_key = {$urandom, $urandom, $urandom, $urandom};
    msg_de = rnd_pt; key = rnd_key; io_ready = 1'b1;
    @(negedge Clk);
    span++;
    // First start edge through second start edge, inclusive.
    check("b2b_span", 128'(span), 128'd13);
    check("b2b_started", 128'(cur_state), 128'd1);
    edges = 1;
    wait_ready(edges);
    check("b2b_latency", 128'(edges), 128'd11);
    check("b2b_ct", msg_en, aes_ref(rnd_pt, rnd_key));
    io_ready = 1'b0;
    @(negedge Clk);

    // Reset in the middle of round 5: abort, outputs clear immediately.
    msg_de = B_PT; key = B_KEY; io_ready = 1'b1;
    @(negedge Clk);
    io_ready = 1'b0;
    repeat (4) @(negedge Clk);
    check("pre_reset_state", 128'(cur_state), 128'd1);
    #2 Reset = 1'b1;
    #1;
    check("mid_reset_state", 128'(cur_state), 128'd0);
    check("mid_reset_ready", 128'(aes_ready), 128'd0);
    check("mid_reset_msg",   msg_en, 128'd0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("post_reset_idle", 128'(cur_state), 128'd0);
    msg_de = C_PT; key = C_KEY; io_ready = 1'b1;
    @(negedge Clk);
    edges = 1;
    wait_ready(edges);
    check("post_reset_latency", 128'(edges), 128'd11);
    check("post_reset_ct", msg_en, C_CT);
    io_ready = 1'b0;
    repeat (2) @(negedge Clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
